// File: rtl/interrupt_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: channel aliases, NONE code and
// arbitration FSM state encodings.
package interrupt_arbiter_pkg;

  localparam int unsigned INT_NONE = 0;

  // Default 3-channel map (activeInt codes)
  localparam int unsigned RST_i = 1;
  localparam int unsigned NMI_i = 2;
  localparam int unsigned IRQ_i = 3;

  // Arbitration FSM states
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Minimum activeInt width able to encode NONE plus every channel
  function automatic int unsigned minVecW(input int unsigned numInt);
    return $clog2(numInt + 1);
  endfunction

endpackage

// File: rtl/interrupt_arbiter_int_sync_pending.sv
// One interrupt channel: two-flop synchroniser, previous-sample flop for
// falling-edge detection, and the edge-sticky / level pending flop.
module int_sync_pending
  import interrupt_arbiter_pkg::*;
(
  input  logic fclk,
  input  logic RES_L,
  input  logic intL,
  input  logic edgeMode,
  input  logic clr,
  output logic pending
);

  logic s0;
  logic s1;
  logic prev;
  logic fallSeen;

  assign fallSeen = prev & ~s1;

  // Synchronise the pin and track pending; a new edge beats a same-cycle clear
  always_ff @(posedge fclk or negedge RES_L) begin
    if (!RES_L) begin
      s0      <= 1'b1;
      s1      <= 1'b1;
      prev    <= 1'b1;
      pending <= 1'b0;
    end else begin
      s0   <= intL;
      s1   <= s0;
      prev <= s1;
      if (!edgeMode) begin
        pending <= ~s1;
      end else if (fallSeen) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// N-channel interrupt capture and fixed-priority arbitration. Channel 0 is
// unmaskable and preempts any other active service.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INT = 3,
  parameter int unsigned VEC_W   = 3
) (
  input  logic               fclk,
  input  logic               RES_L,
  input  logic               haltAll,
  input  logic [NUM_INT-1:0] int_L,
  input  logic [NUM_INT-1:0] edgeMode,
  input  logic [NUM_INT-1:0] mask,
  input  logic               intHandled,
  output logic [VEC_W-1:0]   activeInt,
  output logic               intValid,
  output logic [NUM_INT-1:0] pendingOut
);

  if (NUM_INT < 1 || NUM_INT > 15) begin : gBadNumInt
    $error("interrupt_arbiter: NUM_INT must be 1..15");
  end
  if (VEC_W < minVecW(NUM_INT)) begin : gBadVecW
    $error("interrupt_arbiter: VEC_W too narrow for NUM_INT");
  end

  logic [0:0]         state;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] eligible;
  logic [NUM_INT-1:0] clr;
  logic [VEC_W-1:0]   grantCode;
  logic               anyEligible;
  logic               serviceDone;

  // Channel 0 is always enabled regardless of its mask bit
  assign eligible    = pending & (mask | NUM_INT'(1));
  assign serviceDone = ~haltAll & intHandled & (state == ACTIVE);

  for (genvar g = 0; g < NUM_INT; g++) begin : gChan
    assign clr[g] = serviceDone & (activeInt == VEC_W'(g + 1));

    int_sync_pending uChan (
      .fclk     (fclk),
      .RES_L    (RES_L),
      .intL     (int_L[g]),
      .edgeMode (edgeMode[g]),
      .clr      (clr[g]),
      .pending  (pending[g])
    );
  end

  // Priority encoder: lowest eligible index wins
  always_comb begin
    grantCode   = VEC_W'(INT_NONE);
    anyEligible = 1'b0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (!anyEligible && eligible[i]) begin
        anyEligible = 1'b1;
        grantCode   = VEC_W'(i + 1);
      end
    end
  end

  // Grant / service / preempt FSM; everything freezes while halted
  always_ff @(posedge fclk or negedge RES_L) begin
    if (!RES_L) begin
      state     <= IDLE;
      activeInt <= '0;
    end else if (!haltAll) begin
      if (state == IDLE) begin
        if (anyEligible) begin
          activeInt <= grantCode;
          state     <= ACTIVE;
        end else begin
          activeInt <= VEC_W'(INT_NONE);
        end
      end else if (intHandled) begin
        activeInt <= VEC_W'(INT_NONE);
        state     <= IDLE;
      end else if (pending[0] && activeInt != VEC_W'(1)) begin
        activeInt <= VEC_W'(1);
      end
    end
  end

  assign intValid   = (activeInt != VEC_W'(INT_NONE));
  assign pendingOut = pending;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Randomised scoreboard bench for interrupt_arbiter. A pin-history model
// predicts pending/activeInt per clock; a monitor compares each cycle.
module tb_interrupt_arbiter;

  localparam int NUM_INT = 3;
  localparam int VEC_W   = 3;

  logic               fclk       = 1'b0;
  logic               RES_L      = 1'b0;
  logic               haltAll    = 1'b0;
  logic [NUM_INT-1:0] int_L      = '1;
  logic [NUM_INT-1:0] edgeMode   = 3'b110;
  logic [NUM_INT-1:0] mask       = 3'b111;
  logic               intHandled = 1'b0;
  logic [VEC_W-1:0]   activeInt;
  logic               intValid;
  logic [NUM_INT-1:0] pendingOut;

  typedef struct packed {
    logic [VEC_W-1:0]   act;
    logic [NUM_INT-1:0] pend;
  } exp_t;

  exp_t expQ[$];
  int unsigned passCnt  = 0;
  int unsigned totalCnt = 0;

  always #5 fclk = ~fclk;

  interrupt_arbiter #(.NUM_INT(NUM_INT), .VEC_W(VEC_W)) dut (
    .fclk       (fclk),
    .RES_L      (RES_L),
    .haltAll    (haltAll),
    .int_L      (int_L),
    .edgeMode   (edgeMode),
    .mask       (mask),
    .intHandled (intHandled),
    .activeInt  (activeInt),
    .intValid   (intValid),
    .pendingOut (pendingOut)
  );

  task automatic check(input string nm, input int got, input int want);
    totalCnt++;
    if (got == want) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
  endtask

  // Reference model: pending derived from pin samples two/three clocks back;
  // activeInt == 0 stands for "no service in progress".
  initial begin : model
    logic [NUM_INT-1:0] h1, h2, h3, mPend, oldPend, elig;
    int mAct, oldAct, win, clrCh;
    h1 = '1; h2 = '1; h3 = '1; mPend = '0; mAct = 0;
    forever begin
      @(posedge fclk);
      if (!RES_L) begin
        h1 = '1; h2 = '1; h3 = '1; mPend = '0; mAct = 0;
      end else begin
        oldPend = mPend;
        oldAct  = mAct;
        elig    = oldPend & (mask | 3'b001);
        win     = 0;
        for (int i = NUM_INT - 1; i >= 0; i--) if (elig[i]) win = i + 1;
        clrCh = -1;
        if (!haltAll) begin
          if (oldAct == 0) begin
            if (win != 0) mAct = win;
          end else if (intHandled) begin
            clrCh = oldAct - 1;
            mAct  = 0;
          end else if (oldPend[0] && oldAct != 1) begin
            mAct = 1;
          end
        end
        for (int i = 0; i < NUM_INT; i++) begin
          if (!edgeMode[i])            mPend[i] = ~h2[i];
          else if (h3[i] && !h2[i])    mPend[i] = 1'b1;
          else if (clrCh == i)         mPend[i] = 1'b0;
        end
        h3 = h2; h2 = h1; h1 = int_L;
      end
      expQ.push_back('{act: VEC_W'(mAct), pend: mPend});
    end
  end

  // Monitor: one expected entry per clock, compared mid-cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge fclk);
      if (expQ.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = expQ.pop_front();
        check("activeInt", int'(activeInt), int'(e.act));
        check("pendingOut", int'(pendingOut), int'(e.pend));
        check("intValid", int'(intValid), int'(e.act != 0));
      end
    end
  end

  task automatic randomCycle();
    @(negedge fclk);
    #1;
    for (int i = 0; i < NUM_INT; i++) begin
      if ($urandom_range(0, (i == 0) ? 24 : 6) == 0) int_L[i] = ~int_L[i];
    end
    intHandled = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 15) == 0) haltAll = ~haltAll;
    if ($urandom_range(0, 31) == 0) mask = NUM_INT'($urandom);
  endtask

  // Force a channel-0 request, wait for a grant, then reset asynchronously
  task automatic resetMidService();
    bit got;
    @(negedge fclk);
    #1;
    haltAll = 1'b0; intHandled = 1'b0; int_L[0] = 1'b1;
    @(negedge fclk);
    #1;
    int_L[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge fclk);
      #1;
      if (activeInt != 0) got = 1'b1;
    end
    check("grant_before_reset_timeout", int'(got), 1);
    #1;
    RES_L = 1'b0;
    #1;
    check("async_reset_activeInt", int'(activeInt), 0);
    check("async_reset_intValid", int'(intValid), 0);
    check("async_reset_pendingOut", int'(pendingOut), 0);
    edgeMode = NUM_INT'($urandom);
    mask     = NUM_INT'($urandom);
    int_L    = NUM_INT'($urandom);
    @(negedge fclk);
    #1;
    RES_L = 1'b1;
  endtask

  initial begin : stimulus
    repeat (2) @(negedge fclk);
    #1;
    RES_L = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 400; c++) randomCycle();
      resetMidService();
    end
    repeat (4) @(negedge fclk);
    #2;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
